// File: rtl/dcache_pkg.sv
// Shared definitions for the MEM-stage data-cache controller.
//   - Default geometry (lines, words per line, word-address width) and the
//     offset/index/tag field widths derived from it.
//   - 2-bit FSM state encoding.
//   - Bit positions inside the EX/MEM mem_control field.
package dcache_pkg;

  localparam int DC_LINES  = 8;
  localparam int DC_WORDS  = 4;
  localparam int DC_ADDR_W = 16;
  localparam int DC_DATA_W = 16;

  localparam int DC_OFF_W = $clog2(DC_WORDS);
  localparam int DC_IDX_W = $clog2(DC_LINES);
  localparam int DC_TAG_W = DC_ADDR_W - DC_OFF_W - DC_IDX_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int MC_LOAD_BIT  = 1;
  localparam int MC_STORE_BIT = 0;

endpackage

// File: rtl/dcache_tag_array.sv
// Valid + tag storage for a direct-mapped cache.
//   clk, rst  : clock; asynchronous active-low reset clears every valid bit
//   idx, tag  : line index and tag under lookup (also the write target)
//   wr_en     : record tag at idx and mark the line valid
//   hit       : combinational: line at idx is valid and its tag matches
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int LINES = DC_LINES,
  parameter int IDX_W = DC_IDX_W,
  parameter int TAG_W = DC_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  input  logic             wr_en,
  output logic             hit
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // NOTE: storage arrays are not reset; the valid bits alone decide whether
  // an entry means anything, which keeps the arrays plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[idx] <= tag;
    end
  end

  assign hit = valid_q[idx] && (tag_q[idx] == tag);

endmodule

// File: rtl/mem_dcache_ctrl.sv
// MEM-stage data-cache controller: direct-mapped, write-through,
// no-write-allocate, line fills over a single-outstanding req/ack port.
//   clk, rst        : clock; asynchronous active-low reset
//   mem_control     : [1]=load, [0]=store (11 behaves as a store)
//   addr, wdata     : word address and store data from EX/MEM
//   rdata           : load data, valid when load && !stall_dcache
//   stall_dcache    : freezes EX/MEM and earlier stages
//   mem_req/mem_we/mem_addr/mem_wdata : registered main-memory request
//   mem_ack/mem_rdata                 : one-cycle accept and read return
// Optional build macro DCACHE_STATS_EN adds saturating hit_cnt/miss_cnt.
module mem_dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = DC_LINES,
  parameter int WORDS  = DC_WORDS,
  parameter int ADDR_W = DC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_control,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              stall_dcache,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign off = addr[OFF_W-1:0];
  assign idx = addr[OFF_W +: IDX_W];
  assign tag = addr[ADDR_W-1 -: TAG_W];

  logic is_store, is_load;
  assign is_store = mem_control[MC_STORE_BIT];
  assign is_load  = mem_control[MC_LOAD_BIT] && !is_store;

  logic [1:0]       state, state_n;
  logic [OFF_W-1:0] cnt;
  logic [OFF_W-1:0] cnt_nxt;
  logic             hit;
  logic             ack_ok;
  logic             last_word;
  logic             fill_we, wr_hit_we, tag_we;

  assign cnt_nxt   = cnt + OFF_W'(1);
  assign last_word = &cnt;
  // An ack only counts against an outstanding request.
  assign ack_ok    = mem_ack && mem_req;
  assign fill_we   = (state == ST_FILL) && ack_ok;
  assign tag_we    = fill_we && last_word;
  assign wr_hit_we = (state == ST_WRITE) && ack_ok && hit;

  dcache_tag_array #(
    .LINES(LINES),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_tags (
    .clk  (clk),
    .rst  (rst),
    .idx  (idx),
    .tag  (tag),
    .wr_en(tag_we),
    .hit  (hit)
  );

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (is_store)            state_n = ST_WRITE;
        else if (is_load && !hit) state_n = ST_FILL;
      end
      ST_FILL:  if (ack_ok && last_word) state_n = ST_DONE;
      ST_WRITE: if (ack_ok)              state_n = ST_DONE;
      default:                           state_n = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, including the
  // combinational stall and read paths.
  assign stall_dcache = rst && (((state == ST_IDLE) && (is_store || (is_load && !hit)))
                                || (state == ST_FILL) || (state == ST_WRITE));

  logic [15:0] data_q [LINES][WORDS];

  assign rdata = (rst && is_load && (((state == ST_IDLE) && hit) || (state == ST_DONE)))
                 ? data_q[idx][off] : 16'h0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (is_store) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= wdata;
          end else if (is_load && !hit) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {tag, idx, OFF_W'(0)};
            cnt      <= '0;
          end
        end
        ST_FILL: begin
          if (ack_ok) begin
            // Counter wraps back to 0 on the final word.
            cnt <= cnt_nxt;
            if (last_word) mem_req  <= 1'b0;
            else           mem_addr <= {tag, idx, cnt_nxt};
          end
        end
        ST_WRITE: begin
          if (ack_ok) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Fill words land at the fill counter; a write-through store updates the
  // cached copy only when the line is already resident.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[idx][cnt] <= mem_rdata;
    end else if (wr_hit_we) begin
      data_q[idx][off] <= wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic hit_inc, miss_inc;
  assign hit_inc  = (state == ST_IDLE) && is_load && hit;
  assign miss_inc = (state == ST_IDLE) && (state_n == ST_FILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else begin
      if (hit_inc && (hit_cnt != 16'hFFFF))   hit_cnt  <= hit_cnt + 16'd1;
      if (miss_inc && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_dcache_ctrl.sv
// Scoreboard bench for mem_dcache_ctrl. The driver pushes one expected
// completion record per operation; a monitor pops it when the DUT releases
// the stall. A main-memory model checks every read/write request against
// queues of expected addresses and data.
module tb_mem_dcache_ctrl;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mem_control = 2'b00;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        stall_dcache;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  mem_dcache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mem_control (mem_control),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall_dcache(stall_dcache),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  typedef struct {
    logic        is_load;
    logic [15:0] data;
    int          n_rd;
    int          n_wr;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  exp_t        sb_q[$];
  logic [15:0] rd_q[$];
  wr_t         wr_q[$];

  // ---------------- main-memory model ----------------
  logic [15:0] mem [65536];
  int ack_gap  = 0;
  int wait_cnt = 0;
  int rd_acks  = 0;
  int wr_acks  = 0;

  always @(negedge clk) begin
    if (!rst || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = ack_gap;
    end else begin
      if (mem_ack) wait_cnt = ack_gap;
      if (wait_cnt == 0) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          wr_acks++;
          if (wr_q.size() == 0) flag("unexpected memory write");
          else begin
            wr_t w;
            w = wr_q.pop_front();
            check("write addr", {16'h0, mem_addr}, {16'h0, w.a});
            check("write data", {16'h0, mem_wdata}, {16'h0, w.d});
          end
          mem[mem_addr] = mem_wdata;
        end else begin
          rd_acks++;
          if (rd_q.size() == 0) flag("unexpected memory read");
          else begin
            logic [15:0] ea;
            ea = rd_q.pop_front();
            check("fill addr", {16'h0, mem_addr}, {16'h0, ea});
          end
          mem_rdata = mem[mem_addr];
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt--;
      end
    end
  end

  // ---------------- completion monitor ----------------
  logic in_op = 1'b0;
  int   snap_rd = 0, snap_wr = 0, stall_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      in_op = 1'b0;
    end else if (mem_control != 2'b00) begin
      if (!in_op) begin
        in_op     = 1'b1;
        snap_rd   = rd_acks;
        snap_wr   = wr_acks;
        stall_cyc = 0;
      end
      if (stall_dcache) begin
        stall_cyc++;
      end else begin
        in_op = 1'b0;
        if (sb_q.size() == 0) flag("completion with empty scoreboard");
        else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.is_load) check("load data", {16'h0, rdata}, {16'h0, e.data});
          check("stall cycles", stall_cyc, e.stalls);
          check("fill reads", rd_acks - snap_rd, e.n_rd);
          check("mem writes", wr_acks - snap_wr, e.n_wr);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [1:0] mc, input logic [15:0] a, input logic [15:0] d);
    bit done;
    done        = 1'b0;
    mem_control = mc;
    addr        = a;
    wdata       = d;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!stall_dcache) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) flag("stall never released");
    @(posedge clk);
    #1;
    mem_control = 2'b00;
  endtask

  task automatic load_op(input logic [15:0] a, input logic [15:0] data, input bit miss);
    exp_t e;
    logic [15:0] base;
    base      = a & ~16'((1 << DC_OFF_W) - 1);
    e.is_load = 1'b1;
    e.data    = data;
    e.n_rd    = miss ? DC_WORDS : 0;
    e.n_wr    = 0;
    e.stalls  = miss ? 1 + DC_WORDS * (ack_gap + 1) : 0;
    sb_q.push_back(e);
    if (miss) for (int w = 0; w < DC_WORDS; w++) rd_q.push_back(base + 16'(w));
    issue(2'b10, a, 16'h0000);
  endtask

  task automatic store_op(input logic [1:0] mc, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    wr_t  w;
    e.is_load = 1'b0;
    e.data    = 16'h0000;
    e.n_rd    = 0;
    e.n_wr    = 1;
    e.stalls  = 1 + (ack_gap + 1);
    sb_q.push_back(e);
    w.a = a;
    w.d = d;
    wr_q.push_back(w);
    issue(mc, a, d);
  endtask

  initial begin
    bit reached;
    int base_rd;

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      mem[16'h0010 + i] = 16'h00A0 + 16'(i);
      mem[16'h0110 + i] = 16'h00C0 + 16'(i);
      mem[16'h0008 + i] = 16'h0080 + 16'(i);
    end

    #1 rst = 1'b0;
    #2;
    check("reset mem_req",   {31'h0, mem_req},      32'h0);
    check("reset mem_we",    {31'h0, mem_we},       32'h0);
    check("reset mem_addr",  {16'h0, mem_addr},     32'h0);
    check("reset mem_wdata", {16'h0, mem_wdata},    32'h0);
    check("reset stall",     {31'h0, stall_dcache}, 32'h0);
    check("reset rdata",     {16'h0, rdata},        32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold fill, then a same-line hit.
    ack_gap = 0;
    load_op(16'h0012, 16'h00A2, 1'b1);
    load_op(16'h0013, 16'h00A3, 1'b0);
    // Write-through store that hits, then read it back from the cache.
    ack_gap = 1;
    store_op(2'b01, 16'h0011, 16'hBEEF);
    load_op(16'h0011, 16'hBEEF, 1'b0);
    // Store miss: one write, no allocation; the later load still misses.
    ack_gap = 0;
    store_op(2'b01, 16'h0400, 16'h1234);
    ack_gap = 2;
    load_op(16'h0400, 16'h1234, 1'b1);
    // Conflict on index 4: new tag evicts, original line refills.
    ack_gap = 0;
    load_op(16'h0112, 16'h00C2, 1'b1);
    load_op(16'h0012, 16'h00A2, 1'b1);
    load_op(16'h0011, 16'hBEEF, 1'b0);
    // mem_control=11 behaves as a store.
    store_op(2'b11, 16'h0013, 16'h5555);
    load_op(16'h0013, 16'h5555, 1'b0);
    // Idle cycles must not touch memory.
    repeat (3) @(posedge clk);
    #1;

    // Reset after the second ack of a fill.
    ack_gap = 1;
    rd_q.push_back(16'h0008);
    rd_q.push_back(16'h0009);
    base_rd     = rd_acks;
    reached     = 1'b0;
    mem_control = 2'b10;
    addr        = 16'h0008;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rd_acks == base_rd + 2) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) flag("second fill ack never seen");
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid-fill reset mem_req", {31'h0, mem_req},      32'h0);
    check("mid-fill reset stall",   {31'h0, stall_dcache}, 32'h0);
    check("mid-fill reset rdata",   {16'h0, rdata},        32'h0);
    check("mid-fill reset mem_we",  {31'h0, mem_we},       32'h0);
    mem_control = 2'b00;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Partially filled line stays invalid; all other lines were cleared too.
    ack_gap = 0;
    load_op(16'h0008, 16'h0080, 1'b1);
    load_op(16'h0012, 16'h00A2, 1'b1);
    load_op(16'h0013, 16'h5555, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard drained", sb_q.size(), 32'h0);
    check("fill queue drained", rd_q.size(), 32'h0);
    check("write queue drained", wr_q.size(), 32'h0);
`ifdef DCACHE_STATS_EN
    check("hit_cnt",  {16'h0, hit_cnt},  32'd1);
    check("miss_cnt", {16'h0, miss_cnt}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
